sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, meaning the number of sprite table entries (1..8).
REQ-002 SHALL have parameter SCREEN_H, default 480, meaning the first non-visible line, which triggers a commit.
REQ-003 SHALL have port i_pix_clk, input, 1 bit: the pixel clock, which is the only clock.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_horz_coord, input, 16 bits: current pixel column.
REQ-006 SHALL have port i_vert_coord, input, 16 bits: current pixel line.
REQ-007 SHALL have port i_in_active_area, input, 1 bit: current pixel is visible.
REQ-008 SHALL have port i_wr_valid, input, 1 bit: table write request.
REQ-009 SHALL have port o_wr_ready, output, 1 bit: write accepted when high together with i_wr_valid.
REQ-010 SHALL have port i_wr_sel, input, 3 bits: sprite index to write.
REQ-011 SHALL have port i_wr_field, input, 2 bits: field to write (0=X, 1=Y, 2=ATTR, 3=reserved).
REQ-012 SHALL have port i_wr_data, input, 16 bits: write data; for ATTR, bit 3 is enable and bits 2:0 are the pattern.
REQ-013 SHALL have port o_hit, output, 1 bit: a sprite covers the pixel.
REQ-014 SHALL have port o_sprite_id, output, 3 bits: index of the winning sprite.
REQ-015 SHALL have port o_mem_addr, output, 9 bits: sprite memory address {pattern, row, col}.
REQ-016 SHALL have port o_busy, output, 1 bit: commit in progress.

Function
REQ-017 SHALL hold two tables, shadow and active, each with X[15:0], Y[15:0], EN and PAT[2:0] per sprite.
REQ-018 Writes SHALL update only the shadow table and SHALL set a dirty flag.
REQ-019 Writes with i_wr_sel >= NUM_SPRITES or i_wr_field = 3 SHALL be accepted (handshake completes) and SHALL be discarded without setting dirty.
REQ-020 The FSM SHALL have states IDLE (clean), PENDING (dirty) and COMMIT.
- IDLE -> PENDING on an accepted valid write.
- PENDING -> COMMIT in the cycle where i_vert_coord == SCREEN_H and i_horz_coord == 0.
- An accepted write in the trigger cycle SHALL be included in the commit.
REQ-021 COMMIT SHALL copy one entry per cycle, shadow to active, index 0 through NUM_SPRITES-1; it SHALL then clear dirty and return to IDLE.
REQ-022 A trigger from IDLE SHALL cause no action.
REQ-023 o_wr_ready SHALL be low only in COMMIT; o_busy SHALL be high only in COMMIT.
REQ-024 Sprite k SHALL hit when all of the following are true, using 17-bit unsigned compares with no wrap-around:
- EN is set;
- i_in_active_area is high;
- X <= i_horz_coord < X+8;
- Y <= i_vert_coord < Y+8.
REQ-025 When several sprites hit, the lowest index SHALL win.
REQ-026 o_mem_addr SHALL be {PAT, (vert - Y)[2:0], (horz - X)[2:0]} of the winner.
REQ-027 o_hit, o_sprite_id and o_mem_addr SHALL be registered, with 1-cycle latency from the coordinates.
REQ-028 When there is no hit, o_hit, o_sprite_id and o_mem_addr SHALL be 0.
REQ-029 The pixel path SHALL always read the active table, including during COMMIT; partially committed entries are visible.

Reset
REQ-030 On i_rst, both tables SHALL clear to 0 (all sprites disabled), dirty SHALL clear, and the state SHALL become IDLE.
REQ-031 On i_rst, o_hit, o_sprite_id, o_mem_addr and o_busy SHALL be 0, and o_wr_ready SHALL be 1.
REQ-032 Reset asserted mid-COMMIT SHALL abort the copy immediately; no entry retains committed data.

Structure
REQ-033 The shared package sprite_pkg SHALL hold:
- SPRITE_DIM = 8;
- field codes X/Y/ATTR;
- FSM state encoding;
- the sprite entry struct.
REQ-034 There SHALL be one sub-module, sprite_hit_cmp, instantiated per sprite, producing the hit flag and the row/col offsets.

Verification
REQ-035 Reset, then write sprite 0 with X=100, Y=50, ATTR=0x9, then drive line 480 col 0: o_busy SHALL be high for 4 cycles; at (103,52) active, o_hit SHALL be 1, id 0, addr 0x053.
REQ-036 Sprites 0 and 1 both enabled, both at X=10, Y=10: pixel (12,12) SHALL give id 0; disabling sprite 0 and committing SHALL give id 1.
REQ-037 Write during COMMIT: o_wr_ready SHALL be 0 and the write SHALL be held until ready is 1; the data SHALL appear only after the next commit.
REQ-038 Edge pixels with sprite at X=200, Y=0:
- pixels 199 and 208 SHALL miss;
- 200 and 207 SHALL hit;
- X=65535 SHALL never hit at column 0 (no wrap);
- hits at i_in_active_area=0 SHALL be suppressed.
REQ-039 Write in the trigger cycle from IDLE SHALL be committed in that frame.
REQ-040 i_rst pulsed in the second COMMIT cycle: all outputs SHALL return to reset values, and no hit SHALL occur afterwards without new writes plus a commit.
REQ-041 Write with i_wr_sel = 5 (NUM_SPRITES = 4) SHALL be accepted, SHALL leave the state IDLE, and SHALL change nothing.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: geometry, write field codes, commit FSM states
// and the per-sprite table entry.
package sprite_pkg;

  localparam int SPRITE_DIM = 8;

  typedef enum logic [1:0] {
    FLD_X    = 2'd0,
    FLD_Y    = 2'd1,
    FLD_ATTR = 2'd2
  } fld_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
    logic [2:0]  pat;
  } sprite_t;

endpackage

// File: rtl/sprite_hit_cmp.sv
// Per-sprite coverage test: 17-bit unsigned window compare (no wrap past
// 65535) plus the row/col offset inside the 8x8 cell.
module sprite_hit_cmp
  import sprite_pkg::*;
(
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_en,
  input  logic [15:0] i_horz,
  input  logic [15:0] i_vert,
  input  logic        i_active,
  output logic        o_hit,
  output logic [2:0]  o_row,
  output logic [2:0]  o_col
);
  logic [16:0] w_h, w_v, w_x, w_y;
  logic        w_in_x, w_in_y;

  assign w_h = {1'b0, i_horz};
  assign w_v = {1'b0, i_vert};
  assign w_x = {1'b0, i_x};
  assign w_y = {1'b0, i_y};

  assign w_in_x = (w_h >= w_x) && (w_h < w_x + 17'(SPRITE_DIM));
  assign w_in_y = (w_v >= w_y) && (w_v < w_y + 17'(SPRITE_DIM));
  assign o_hit  = i_en && i_active && w_in_x && w_in_y;

  // Low bits of a difference depend only on the low bits of the operands.
  assign o_row = i_vert[2:0] - i_y[2:0];
  assign o_col = i_horz[2:0] - i_x[2:0];
endmodule

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite table with a frame-synchronous commit and a
// registered lowest-index-wins pixel hit path.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SCREEN_H    = 480
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic [15:0] i_horz_coord,
  input  logic [15:0] i_vert_coord,
  input  logic        i_in_active_area,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [2:0]  i_wr_sel,
  input  logic [1:0]  i_wr_field,
  input  logic [15:0] i_wr_data,
  output logic        o_hit,
  output logic [2:0]  o_sprite_id,
  output logic [8:0]  o_mem_addr,
  output logic        o_busy
);
  sprite_t [NUM_SPRITES-1:0] r_shadow, r_active;
  state_e                    r_state, w_state_nxt;
  logic [2:0]                r_idx;
  logic                      w_trigger, w_wr_ok, w_last;

  logic [NUM_SPRITES-1:0]      w_hit;
  logic [NUM_SPRITES-1:0][2:0] w_row, w_col;
  logic                        w_any;
  logic [2:0]                  w_id;
  logic [8:0]                  w_addr;
  logic                        r_hit;
  logic [2:0]                  r_id;
  logic [8:0]                  r_addr;

  assign w_trigger = (i_vert_coord == 16'(SCREEN_H)) && (i_horz_coord == 16'd0);
  assign w_wr_ok   = i_wr_valid && o_wr_ready && ({1'b0, i_wr_sel} < 4'(NUM_SPRITES))
                     && (i_wr_field != 2'd3);
  assign w_last    = (r_idx == 3'(NUM_SPRITES - 1));

  // PENDING is the dirty flag: only a kept write leaves IDLE, and only the
  // end of a commit returns there.
  always_comb begin
    w_state_nxt = r_state;
    o_wr_ready  = 1'b1;
    o_busy      = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_wr_ok) w_state_nxt = w_trigger ? ST_COMMIT : ST_PENDING;
      ST_PENDING: if (w_trigger) w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        o_wr_ready = 1'b0;
        o_busy     = 1'b1;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= (r_state == ST_COMMIT && !w_last) ? r_idx + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (w_wr_ok && i_wr_sel == 3'(k)) begin
          case (fld_e'(i_wr_field))
            FLD_X:    r_shadow[k].x <= i_wr_data;
            FLD_Y:    r_shadow[k].y <= i_wr_data;
            FLD_ATTR: begin
              r_shadow[k].en  <= i_wr_data[3];
              r_shadow[k].pat <= i_wr_data[2:0];
            end
            default: ;
          endcase
        end
        if (r_state == ST_COMMIT && r_idx == 3'(k)) r_active[k] <= r_shadow[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cmp
    sprite_hit_cmp u_cmp (
      .i_x      (r_active[g].x),
      .i_y      (r_active[g].y),
      .i_en     (r_active[g].en),
      .i_horz   (i_horz_coord),
      .i_vert   (i_vert_coord),
      .i_active (i_in_active_area),
      .o_hit    (w_hit[g]),
      .o_row    (w_row[g]),
      .o_col    (w_col[g])
    );
  end

  // Scan high to low so the lowest hitting index is the last assignment.
  always_comb begin
    w_any  = 1'b0;
    w_id   = 3'd0;
    w_addr = 9'd0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any  = 1'b1;
        w_id   = 3'(k);
        w_addr = {r_active[k].pat, w_row[k], w_col[k]};
      end
    end
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit  <= 1'b0;
      r_id   <= 3'd0;
      r_addr <= 9'd0;
    end else begin
      r_hit  <= w_any;
      r_id   <= w_id;
      r_addr <= w_addr;
    end
  end

  assign o_hit       = r_hit;
  assign o_sprite_id = r_id;
  assign o_mem_addr  = r_addr;
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: commit timing, priority, stalled
// writes, window edges, trigger-cycle writes, reset abort, discarded writes.
module tb_sprite_scheduler;
  logic        i_pix_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] i_horz_coord = '0, i_vert_coord = '0;
  logic        i_in_active_area = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [2:0]  i_wr_sel = '0;
  logic [1:0]  i_wr_field = '0;
  logic [15:0] i_wr_data = '0;
  logic        o_hit;
  logic [2:0]  o_sprite_id;
  logic [8:0]  o_mem_addr;
  logic        o_busy;

  int n_vec = 0;
  int n_err = 0;

  sprite_scheduler #(.NUM_SPRITES(4), .SCREEN_H(480)) dut (
    .i_pix_clk(i_pix_clk), .i_rst(i_rst),
    .i_horz_coord(i_horz_coord), .i_vert_coord(i_vert_coord),
    .i_in_active_area(i_in_active_area),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_sel(i_wr_sel), .i_wr_field(i_wr_field), .i_wr_data(i_wr_data),
    .o_hit(o_hit), .o_sprite_id(o_sprite_id), .o_mem_addr(o_mem_addr),
    .o_busy(o_busy)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  task automatic do_reset();
    @(negedge i_pix_clk);
    i_rst = 1'b1; i_wr_valid = 1'b0; i_in_active_area = 1'b0;
    i_horz_coord = 16'd1; i_vert_coord = 16'd0;
    @(negedge i_pix_clk);
    i_rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [1:0] fld, input logic [15:0] data);
    int t = 0;
    @(negedge i_pix_clk);
    i_wr_valid = 1'b1; i_wr_sel = sel; i_wr_field = fld; i_wr_data = data;
    while (!o_wr_ready && t < 50) begin @(negedge i_pix_clk); t++; end
    if (!o_wr_ready) begin
      n_vec++; n_err++;
      $display("FAIL wr_timeout: ready=%b required 1", o_wr_ready);
    end
    @(posedge i_pix_clk); #1;
    i_wr_valid = 1'b0;
  endtask

  // Drives the commit trigger for one cycle and counts busy cycles after it.
  task automatic commit(output int busy_n);
    busy_n = 0;
    @(negedge i_pix_clk);
    i_vert_coord = 16'd480; i_horz_coord = 16'd0; i_in_active_area = 1'b0;
    @(negedge i_pix_clk);
    i_vert_coord = 16'd0; i_horz_coord = 16'd1;
    for (int c = 0; c < 20; c++) begin
      if (o_busy) busy_n++;
      @(negedge i_pix_clk);
    end
  endtask

  task automatic pix(input logic [15:0] h, input logic [15:0] v, input logic act,
                     output logic [12:0] r);
    @(negedge i_pix_clk);
    i_horz_coord = h; i_vert_coord = v; i_in_active_area = act;
    @(posedge i_pix_clk); #1;
    r = {o_hit, o_sprite_id, o_mem_addr};
  endtask

  task automatic test_reset();
    @(negedge i_pix_clk);
    i_rst = 1'b1;
    #1;
    n_vec++;
    if ({o_hit, o_sprite_id, o_mem_addr, o_busy} !== 14'd0) begin
      n_err++; $display("FAIL reset_outs: got %h required 0", {o_hit, o_sprite_id, o_mem_addr, o_busy});
    end
    n_vec++;
    if (o_wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", o_wr_ready); end
    @(negedge i_pix_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [12:0] r; int b;
    do_reset();
    wr(3'd0, 2'd0, 16'd100); wr(3'd0, 2'd1, 16'd50); wr(3'd0, 2'd2, 16'h9);
    pix(16'd103, 16'd52, 1'b1, r);
    n_vec++;
    if (r !== 13'd0) begin n_err++; $display("FAIL basic_precommit: got %h required 0", r); end
    commit(b);
    n_vec++;
    if (b != 4) begin n_err++; $display("FAIL basic_busy: got %0d cycles required 4", b); end
    pix(16'd103, 16'd52, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd0, 9'h053}) begin n_err++; $display("FAIL basic_hit: got %h required %h", r, {1'b1, 3'd0, 9'h053}); end
  endtask

  task automatic test_priority();
    logic [12:0] r; int b;
    do_reset();
    wr(3'd0, 2'd0, 16'd10); wr(3'd0, 2'd1, 16'd10); wr(3'd0, 2'd2, 16'h8);
    wr(3'd1, 2'd0, 16'd10); wr(3'd1, 2'd1, 16'd10); wr(3'd1, 2'd2, 16'hA);
    commit(b);
    pix(16'd12, 16'd12, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd0, 9'h012}) begin n_err++; $display("FAIL prio_low: got %h required %h", r, {1'b1, 3'd0, 9'h012}); end
    wr(3'd0, 2'd2, 16'h0);
    pix(16'd12, 16'd12, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd0, 9'h012}) begin n_err++; $display("FAIL prio_shadow: got %h required %h", r, {1'b1, 3'd0, 9'h012}); end
    commit(b);
    pix(16'd12, 16'd12, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd1, 9'h092}) begin n_err++; $display("FAIL prio_next: got %h required %h", r, {1'b1, 3'd1, 9'h092}); end
  endtask

  // Runs on the table left by test_priority (sprite 1 at 10,10).
  task automatic test_wr_during_commit();
    logic [12:0] r; int b; int t = 0;
    wr(3'd2, 2'd1, 16'd100); wr(3'd2, 2'd2, 16'h8);
    @(negedge i_pix_clk);
    i_vert_coord = 16'd480; i_horz_coord = 16'd0; i_in_active_area = 1'b0;
    @(negedge i_pix_clk);
    i_vert_coord = 16'd0; i_horz_coord = 16'd1;
    i_wr_valid = 1'b1; i_wr_sel = 3'd2; i_wr_field = 2'd0; i_wr_data = 16'd300;
    #1;
    n_vec++;
    if ({o_busy, o_wr_ready} !== 2'b10) begin n_err++; $display("FAIL commit_stall: busy,ready=%b required 10", {o_busy, o_wr_ready}); end
    while (!o_wr_ready && t < 20) begin @(negedge i_pix_clk); t++; end
    n_vec++;
    if (!o_wr_ready) begin n_err++; $display("FAIL commit_release: ready=%b required 1", o_wr_ready); end
    @(posedge i_pix_clk); #1;
    i_wr_valid = 1'b0;
    pix(16'd302, 16'd101, 1'b1, r);
    n_vec++;
    if (r !== 13'd0) begin n_err++; $display("FAIL held_not_yet: got %h required 0", r); end
    pix(16'd2, 16'd101, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd2, 9'h00A}) begin n_err++; $display("FAIL held_old_x: got %h required %h", r, {1'b1, 3'd2, 9'h00A}); end
    commit(b);
    n_vec++;
    if (b != 4) begin n_err++; $display("FAIL held_busy: got %0d cycles required 4", b); end
    pix(16'd302, 16'd101, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd2, 9'h00A}) begin n_err++; $display("FAIL held_new_x: got %h required %h", r, {1'b1, 3'd2, 9'h00A}); end
  endtask

  task automatic test_edges();
    logic [12:0] r; int b;
    logic [15:0] hs [7]  = '{16'd199, 16'd200, 16'd207, 16'd208, 16'd0, 16'd65535, 16'd203};
    logic        act [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [12:0] exp [7] = '{13'd0, {1'b1, 3'd0, 9'h018}, {1'b1, 3'd0, 9'h01F}, 13'd0,
                             13'd0, {1'b1, 3'd1, 9'h018}, 13'd0};
    do_reset();
    wr(3'd0, 2'd0, 16'd200);   wr(3'd0, 2'd2, 16'h8);
    wr(3'd1, 2'd0, 16'd65535); wr(3'd1, 2'd2, 16'h8);
    commit(b);
    for (int i = 0; i < 7; i++) begin
      pix(hs[i], 16'd3, act[i], r);
      n_vec++;
      if (r !== exp[i]) begin n_err++; $display("FAIL edge_h%0d: got %h required %h", hs[i], r, exp[i]); end
    end
  endtask

  task automatic test_trigger_write();
    logic [12:0] r; int b = 0;
    do_reset();
    @(negedge i_pix_clk);
    i_vert_coord = 16'd480; i_horz_coord = 16'd0;
    i_wr_valid = 1'b1; i_wr_sel = 3'd0; i_wr_field = 2'd2; i_wr_data = 16'h8;
    @(negedge i_pix_clk);
    i_wr_valid = 1'b0; i_vert_coord = 16'd0; i_horz_coord = 16'd1;
    for (int c = 0; c < 20; c++) begin
      if (o_busy) b++;
      @(negedge i_pix_clk);
    end
    n_vec++;
    if (b != 4) begin n_err++; $display("FAIL trig_wr_busy: got %0d cycles required 4", b); end
    pix(16'd1, 16'd1, 1'b1, r);
    n_vec++;
    if (r !== {1'b1, 3'd0, 9'h009}) begin n_err++; $display("FAIL trig_wr_hit: got %h required %h", r, {1'b1, 3'd0, 9'h009}); end
    commit(b);
    n_vec++;
    if (b != 0) begin n_err++; $display("FAIL idle_trigger: got %0d busy cycles required 0", b); end
  endtask

  task automatic test_reset_mid_commit();
    logic [12:0] r; int b;
    do_reset();
    wr(3'd0, 2'd2, 16'h8);
    @(negedge i_pix_clk);
    i_vert_coord = 16'd480; i_horz_coord = 16'd0;
    @(negedge i_pix_clk);
    i_vert_coord = 16'd1; i_horz_coord = 16'd1; i_in_active_area = 1'b1;
    @(negedge i_pix_clk);
    i_rst = 1'b1;
    #1;
    n_vec++;
    if ({o_hit, o_sprite_id, o_mem_addr, o_busy, o_wr_ready} !== 15'd1) begin
      n_err++; $display("FAIL abort_outs: got %h required 0001", {o_hit, o_sprite_id, o_mem_addr, o_busy, o_wr_ready});
    end
    @(negedge i_pix_clk);
    i_rst = 1'b0;
    pix(16'd1, 16'd1, 1'b1, r);
    n_vec++;
    if (r !== 13'd0) begin n_err++; $display("FAIL abort_nohit: got %h required 0", r); end
    commit(b);
    n_vec++;
    if (b != 0) begin n_err++; $display("FAIL abort_clean: got %0d busy cycles required 0", b); end
    pix(16'd1, 16'd1, 1'b1, r);
    n_vec++;
    if (r !== 13'd0) begin n_err++; $display("FAIL abort_nohit2: got %h required 0", r); end
  endtask

  task automatic test_bad_sel();
    logic [12:0] r; int b;
    do_reset();
    wr(3'd5, 2'd0, 16'd0); wr(3'd5, 2'd2, 16'h8); wr(3'd0, 2'd3, 16'h8);
    commit(b);
    n_vec++;
    if (b != 0) begin n_err++; $display("FAIL badsel_idle: got %0d busy cycles required 0", b); end
    pix(16'd0, 16'd0, 1'b1, r);
    n_vec++;
    if (r !== 13'd0) begin n_err++; $display("FAIL badsel_nohit: got %h required 0", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_wr_during_commit();
    test_edges();
    test_trigger_write();
    test_reset_mid_commit();
    test_bad_sel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
